// File: rtl/plab2_proc_imem_resp_drop_queue.sv
// plab2_proc_imem_resp_drop_queue: in-order imem response queue with bypass that
// discards squashed responses, including drops signalled before the response returns.
module plab2_proc_imem_resp_drop_queue #(
    parameter int p_msg_nbits      = 32,
    parameter int p_num_entries    = 2,
    parameter int p_drop_cnt_nbits = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [p_msg_nbits-1:0]      in_msg,
    input  logic                        drop,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [p_msg_nbits-1:0]      out_msg,
    output logic [p_drop_cnt_nbits-1:0] drop_cnt,
    output logic                        drop_err
);
    localparam int PW = p_num_entries > 1 ? $clog2(p_num_entries) : 1;
    localparam int CW = $clog2(p_num_entries + 1);
    localparam logic [p_drop_cnt_nbits-1:0] DMAX = '1;
    localparam logic [PW-1:0] PLAST = PW'(p_num_entries - 1);
    logic [p_msg_nbits-1:0]      mem_q [p_num_entries];
    logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [p_drop_cnt_nbits-1:0] dcnt_q, dcnt_d;
    logic                        err_q, err_d;
    logic                        empty, arrive, eat, byp, deq, enq, early;
    always_comb begin
        empty    = cnt_q == '0;
        in_rdy   = !reset && cnt_q != CW'(p_num_entries);
        arrive   = in_val && in_rdy;
        eat      = arrive && dcnt_q != '0;
        byp      = arrive && empty && !eat;
        out_val  = !reset && (!empty || byp);
        out_msg  = empty ? in_msg : mem_q[head_q];
        deq      = !reset && !empty && (drop || out_rdy);
        enq      = arrive && !eat && (!empty || (!drop && !out_rdy));
        // a drop with nothing visible targets a response still in flight
        early    = !reset && drop && !out_val;
        dcnt_d   = (early && !eat) ? (dcnt_q == DMAX ? dcnt_q : dcnt_q + 1'b1)
                 : (eat && !early) ? dcnt_q - 1'b1 : dcnt_q;
        err_d    = err_q || (early && !eat && dcnt_q == DMAX);
        cnt_d    = cnt_q + CW'(enq) - CW'(deq);
        head_d   = deq ? (head_q == PLAST ? '0 : head_q + 1'b1) : head_q;
        tail_d   = enq ? (tail_q == PLAST ? '0 : tail_q + 1'b1) : tail_q;
        drop_cnt = reset ? '0 : dcnt_q;
        drop_err = !reset && err_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            dcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            dcnt_q <= dcnt_d;
            err_q  <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= in_msg;
    end
endmodule

// File: tb/tb_plab2_proc_imem_resp_drop_queue.sv
// tb_plab2_proc_imem_resp_drop_queue: directed tests against a queue-level reference
// model checked every cycle, plus literal expectations per scenario.
module tb_plab2_proc_imem_resp_drop_queue;
    localparam int N    = 2;
    localparam int DMAX = 3;
    logic        clk = 1'b0, reset = 1'b1, in_val = 1'b0, out_rdy = 1'b0, drop = 1'b0;
    logic [31:0] in_msg = '0;
    logic        in_rdy, out_val, drop_err;
    logic [31:0] out_msg;
    logic [1:0]  drop_cnt;
    int tests = 0, fails = 0;
    logic [31:0] mq[$];
    logic [31:0] dlv[$];
    int  dcnt = 0;
    bit  derr = 0;
    bit  e_rdy, arr, e_val;
    logic [31:0] e_msg;

    plab2_proc_imem_resp_drop_queue #(.p_msg_nbits(32), .p_num_entries(N), .p_drop_cnt_nbits(2)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .drop(drop), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
        .drop_cnt(drop_cnt), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: compare at negedge, then advance as the DUT will at the next posedge
    always @(negedge clk) begin
        e_rdy = !reset && mq.size() < N;
        arr   = in_val && e_rdy;
        e_val = !reset && (mq.size() > 0 || (arr && dcnt == 0));
        e_msg = mq.size() > 0 ? mq[0] : in_msg;
        chk("m_in_rdy", {31'b0, in_rdy}, {31'b0, e_rdy});
        chk("m_out_val", {31'b0, out_val}, {31'b0, e_val});
        chk("m_drop_cnt", {30'b0, drop_cnt}, reset ? 0 : dcnt);
        chk("m_drop_err", {31'b0, drop_err}, {31'b0, !reset && derr});
        if (e_val) chk("m_out_msg", out_msg, e_msg);
        if (e_val && out_rdy && !drop) dlv.push_back(e_msg);
        if (reset) begin
            mq.delete();
            dcnt = 0;
            derr = 0;
        end else if (mq.size() > 0) begin
            if (drop || out_rdy) void'(mq.pop_front());
            if (arr) mq.push_back(in_msg);
        end else if (arr && dcnt > 0) begin
            if (!drop) dcnt--;
        end else if (arr) begin
            if (!drop && !out_rdy) mq.push_back(in_msg);
        end else if (drop) begin
            if (dcnt == DMAX) derr = 1;
            else dcnt++;
        end
    end

    task automatic drv(input logic v, input logic [31:0] m, input logic d, input logic r);
        in_val = v; in_msg = m; drop = d; out_rdy = r;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_drop_cnt", {30'b0, drop_cnt}, 0);
        chk("reset_in_rdy", {31'b0, in_rdy}, 1);

        // bypass
        dlv.delete();
        drv(1, 32'h13, 0, 1);
        chk("byp_val", {31'b0, out_val}, 1);
        chk("byp_msg", out_msg, 32'h13);
        tick();
        drv(0, 0, 0, 1);
        chk("byp_empty", {31'b0, out_val}, 0);
        chk("byp_rdy", {31'b0, in_rdy}, 1);
        tick();
        chk("byp_dlv", dlv.size() == 1 ? dlv[0] : 32'hdead, 32'h13);

        // backpressure
        dlv.delete();
        drv(1, 32'h11, 0, 0); tick();
        drv(1, 32'h22, 0, 0); tick();
        drv(1, 32'h33, 0, 0);
        chk("bp_full", {31'b0, in_rdy}, 0);
        tick();
        drv(1, 32'h33, 0, 1);
        chk("bp_full_deq", {31'b0, in_rdy}, 0);
        chk("bp_out0", out_msg, 32'h11);
        tick();
        drv(1, 32'h33, 0, 1);
        chk("bp_rdy_again", {31'b0, in_rdy}, 1);
        chk("bp_out1", out_msg, 32'h22);
        tick();
        drv(0, 0, 0, 1);
        chk("bp_out2", out_msg, 32'h33);
        tick();
        drv(0, 0, 0, 0);
        chk("bp_drained", {31'b0, out_val}, 0);
        tick();
        chk("bp_order", dlv.size() == 3 ? {dlv[0][7:0], dlv[1][7:0], dlv[2][7:0]} : 32'hdead, 32'h112233);

        // head drop
        drv(1, 32'h11, 0, 0); tick();
        drv(1, 32'h22, 0, 0); tick();
        dlv.delete();
        drv(0, 0, 1, 1);
        chk("hd_head", out_msg, 32'h11);
        tick();
        drv(0, 0, 0, 1);
        chk("hd_next", out_msg, 32'h22);
        tick();
        drv(0, 0, 0, 0); tick();
        chk("hd_dlv", dlv.size() == 1 ? dlv[0] : 32'hdead, 32'h22);

        // early drops
        dlv.delete();
        drv(0, 0, 1, 1); tick();
        drv(0, 0, 1, 1); tick();
        drv(0, 0, 0, 1);
        chk("ed_cnt2", {30'b0, drop_cnt}, 2);
        drv(1, 32'h44, 0, 1);
        chk("ed_rdy44", {31'b0, in_rdy}, 1);
        chk("ed_hide44", {31'b0, out_val}, 0);
        tick();
        drv(1, 32'h55, 0, 1);
        chk("ed_cnt1", {30'b0, drop_cnt}, 1);
        chk("ed_hide55", {31'b0, out_val}, 0);
        tick();
        drv(1, 32'h66, 0, 1);
        chk("ed_cnt0", {30'b0, drop_cnt}, 0);
        chk("ed_byp66", out_msg, 32'h66);
        tick();
        drv(0, 0, 0, 0); tick();
        chk("ed_dlv", dlv.size() == 1 ? dlv[0] : 32'hdead, 32'h66);

        // arrival and drop together on an empty queue
        dlv.delete();
        drv(1, 32'h77, 1, 1);
        chk("sd_val", {31'b0, out_val}, 1);
        tick();
        drv(0, 0, 0, 1);
        chk("sd_cnt", {30'b0, drop_cnt}, 0);
        chk("sd_empty", {31'b0, out_val}, 0);
        tick();
        chk("sd_dlv", dlv.size(), 0);

        // drop counter saturation then reset
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 1, 0);
            tick();
        end
        drv(0, 0, 0, 0);
        chk("ov_cnt", {30'b0, drop_cnt}, 3);
        chk("ov_err", {31'b0, drop_err}, 1);
        tick();
        chk("ov_sticky", {31'b0, drop_err}, 1);
        reset = 1'b1;
        #3;
        chk("rst_in_rdy", {31'b0, in_rdy}, 0);
        chk("rst_err", {31'b0, drop_err}, 0);
        tick();
        reset = 1'b0;
        #3;
        chk("post_cnt", {30'b0, drop_cnt}, 0);
        chk("post_err", {31'b0, drop_err}, 0);
        chk("post_val", {31'b0, out_val}, 0);
        chk("post_rdy", {31'b0, in_rdy}, 1);
        tick();

        // reset with buffered data
        drv(1, 32'h88, 0, 0); tick();
        drv(1, 32'h99, 0, 0); tick();
        drv(0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #3;
        chk("rq_val", {31'b0, out_val}, 0);
        chk("rq_rdy", {31'b0, in_rdy}, 1);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
